// File: rtl/crc_mem_loader_if.sv
// Byte-stream and frame-memory bus between the payload producer and the CRC loader.
// The master modport is the producer/observer side; the slave modport is the loader.
interface crc_mem_loader_if #(
  parameter int ADDR_W = 10
);
  logic              load_start;
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              mem_we;
  logic [15:0]       crc_out;
  logic              load_busy;
  logic              load_done;
  logic              load_err;

  modport master (
    output load_start, in_data, in_valid,
    input  in_ready, mem_addr, mem_wdata, mem_we, crc_out,
    input  load_busy, load_done, load_err
  );

  modport slave (
    input  load_start, in_data, in_valid,
    output in_ready, mem_addr, mem_wdata, mem_we, crc_out,
    output load_busy, load_done, load_err
  );
endinterface

// File: rtl/crc_mem_loader.sv
// CRC memory loader: writes a fixed-length byte frame into the frame memory and
// appends its CRC-16-CCITT (poly 0x1021, init 0xFFFF, MSB first) in the last two
// locations, so that a checker reading the whole memory sees a zero residue.
// Optional idle timeout inside a frame is enabled by defining CRC_LOADER_TIMEOUT_EN.
module crc_mem_loader #(
  parameter int ADDR_W         = 10,
  parameter int PAYLOAD_LEN    = 1022,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic               clk50m,
  input  logic               rst_n,
  crc_mem_loader_if.slave    bus
);

  localparam int CNT_W = ADDR_W + 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_PAYLOAD = 3'd1,
    S_CRC_HI  = 3'd2,
    S_CRC_LO  = 3'd3,
    S_DONE    = 3'd4,
    S_ERROR   = 3'd5
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [CNT_W-1:0]   r_count;
  logic [15:0]        r_crc;
  logic               r_mem_we;
  logic [ADDR_W-1:0]  r_mem_addr;
  logic [7:0]         r_mem_wdata;
  logic               r_load_done;
  logic               w_accept;
  logic               w_last_byte;
  logic               w_start_ok;
  logic               w_timeout;
  logic [15:0]        w_crc_next;

  // One byte step of the MSB-first CRC-16-CCITT update
  function automatic logic [15:0] crcUpdate(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] v;
    v = c ^ {d, 8'h00};
    for (int i = 0; i < 8; i++) begin
      v = v[15] ? ((v << 1) ^ 16'h1021) : (v << 1);
    end
    return v;
  endfunction

  assign w_accept    = (r_state == S_PAYLOAD) && bus.in_valid;
  assign w_last_byte = (r_count == CNT_W'(PAYLOAD_LEN - 1));
  assign w_start_ok  = bus.load_start &&
                       ((r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERROR));
  assign w_crc_next  = crcUpdate(r_crc, bus.in_data);

`ifdef CRC_LOADER_TIMEOUT_EN
  localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [IDLE_W-1:0] r_idle;

  // Idle counter: counts PAYLOAD cycles without an accepted byte
  always_ff @(posedge clk50m or negedge rst_n) begin
    if (!rst_n) begin
      r_idle <= '0;
    end else if (w_start_ok || w_accept) begin
      r_idle <= '0;
    end else if (r_state == S_PAYLOAD) begin
      r_idle <= r_idle + 1'b1;
    end
  end

  assign w_timeout = (r_state == S_PAYLOAD) && !bus.in_valid &&
                     (r_idle == IDLE_W'(TIMEOUT_CYCLES - 1));
`else
  assign w_timeout = 1'b0;
`endif

  // State register
  always_ff @(posedge clk50m or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic: a frame runs PAYLOAD -> CRC_HI -> CRC_LO -> DONE
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (bus.load_start) w_next = S_PAYLOAD;
      end
      S_PAYLOAD: begin
        if (w_accept && w_last_byte) w_next = S_CRC_HI;
        else if (w_timeout)          w_next = S_ERROR;
      end
      S_CRC_HI: w_next = S_CRC_LO;
      S_CRC_LO: w_next = S_DONE;
`ifdef CRC_LOADER_TIMEOUT_EN
      S_ERROR: begin
        if (bus.load_start) w_next = S_PAYLOAD;
      end
`endif
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath: byte count, running CRC, registered memory write port and done flag
  always_ff @(posedge clk50m or negedge rst_n) begin
    if (!rst_n) begin
      r_count     <= '0;
      r_crc       <= 16'hFFFF;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_load_done <= 1'b0;
    end else begin
      r_mem_we <= 1'b0;
      if (w_start_ok) begin
        r_count     <= '0;
        r_crc       <= 16'hFFFF;
        r_load_done <= 1'b0;
      end else begin
        case (r_state)
          S_PAYLOAD: begin
            if (w_accept) begin
              r_mem_we    <= 1'b1;
              r_mem_addr  <= r_count[ADDR_W-1:0];
              r_mem_wdata <= bus.in_data;
              r_crc       <= w_crc_next;
              r_count     <= r_count + 1'b1;
            end
          end
          S_CRC_HI: begin
            r_mem_we    <= 1'b1;
            r_mem_addr  <= ADDR_W'(PAYLOAD_LEN);
            r_mem_wdata <= r_crc[15:8];
          end
          S_CRC_LO: begin
            r_mem_we    <= 1'b1;
            r_mem_addr  <= ADDR_W'(PAYLOAD_LEN + 1);
            r_mem_wdata <= r_crc[7:0];
          end
          S_DONE: begin
            r_load_done <= 1'b1;
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign bus.in_ready  = (r_state == S_PAYLOAD);
  assign bus.load_busy = (r_state == S_PAYLOAD) || (r_state == S_CRC_HI) ||
                         (r_state == S_CRC_LO);
  assign bus.load_done = r_load_done;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.crc_out   = r_crc;
`ifdef CRC_LOADER_TIMEOUT_EN
  assign bus.load_err  = (r_state == S_ERROR);
`else
  assign bus.load_err  = 1'b0;
`endif

endmodule

// File: tb/tb_crc_mem_loader.sv
// Testbench for crc_mem_loader: a short-frame instance (9 payload bytes, timeout 16)
// and a default-size instance (1022 bytes), both checked every cycle against a
// frame-level reference model, plus literal CRC/memory expectations.
module tb_crc_mem_loader;

  localparam int AW    = 10;
  localparam int LEN_S = 9;
  localparam int LEN_B = 1022;
  localparam int TO_S  = 16;
  localparam int TO_B  = 65535;

  localparam int P_IDLE = 0, P_PAYLOAD = 1, P_CRC_HI = 2, P_CRC_LO = 3, P_DONE = 4, P_ERROR = 5;

  logic clk50m = 1'b0;
  logic rst_n  = 1'b0;

  always #10 clk50m = ~clk50m;

  crc_mem_loader_if #(.ADDR_W(AW)) bus0 ();
  crc_mem_loader_if #(.ADDR_W(AW)) bus1 ();

  crc_mem_loader #(.ADDR_W(AW), .PAYLOAD_LEN(LEN_S), .TIMEOUT_CYCLES(TO_S)) dut0 (
    .clk50m (clk50m),
    .rst_n  (rst_n),
    .bus    (bus0.slave)
  );

  crc_mem_loader #(.ADDR_W(AW), .PAYLOAD_LEN(LEN_B), .TIMEOUT_CYCLES(TO_B)) dut1 (
    .clk50m (clk50m),
    .rst_n  (rst_n),
    .bus    (bus1.slave)
  );

  logic       tStart [2];
  logic       tValid [2];
  logic [7:0] tData  [2];

  assign bus0.load_start = tStart[0];
  assign bus0.in_valid   = tValid[0];
  assign bus0.in_data    = tData[0];
  assign bus1.load_start = tStart[1];
  assign bus1.in_valid   = tValid[1];
  assign bus1.in_data    = tData[1];

  logic        oReady [2];
  logic        oWe    [2];
  logic        oBusy  [2];
  logic        oDone  [2];
  logic        oErr   [2];
  logic [9:0]  oAddr  [2];
  logic [7:0]  oWd    [2];
  logic [15:0] oCrc   [2];

  assign oReady[0] = bus0.in_ready;
  assign oWe[0]    = bus0.mem_we;
  assign oBusy[0]  = bus0.load_busy;
  assign oDone[0]  = bus0.load_done;
  assign oErr[0]   = bus0.load_err;
  assign oAddr[0]  = bus0.mem_addr;
  assign oWd[0]    = bus0.mem_wdata;
  assign oCrc[0]   = bus0.crc_out;
  assign oReady[1] = bus1.in_ready;
  assign oWe[1]    = bus1.mem_we;
  assign oBusy[1]  = bus1.load_busy;
  assign oDone[1]  = bus1.load_done;
  assign oErr[1]   = bus1.load_err;
  assign oAddr[1]  = bus1.mem_addr;
  assign oWd[1]    = bus1.mem_wdata;
  assign oCrc[1]   = bus1.crc_out;

  // Reference model: frame phase, byte count, running CRC and expected outputs
  int          mPh   [2];
  int          mCnt  [2];
  int          mIdle [2];
  logic [15:0] mCrc  [2];
  logic        mWe   [2];
  logic [9:0]  mAddr [2];
  logic [7:0]  mWd   [2];
  logic        mDone [2];
  int          mLen  [2];
  int          mTo   [2];

  logic [7:0]  memImg  [2][1024];
  int          wrCount [2];

  int nCompared   = 0;
  int nMismatched = 0;

  function automatic logic [15:0] crcByte(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] v;
    v = c ^ {b, 8'h00};
    for (int k = 0; k < 8; k++) v = v[15] ? ((v << 1) ^ 16'h1021) : (v << 1);
    return v;
  endfunction

  function automatic logic [15:0] crcOver(input int d, input int n);
    logic [15:0] c;
    c = 16'hFFFF;
    for (int k = 0; k < n; k++) c = crcByte(c, memImg[d][k]);
    return c;
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic modelReset(input int d);
    mPh[d] = P_IDLE;  mCnt[d] = 0;  mIdle[d] = 0;  mCrc[d] = 16'hFFFF;
    mWe[d] = 1'b0;    mAddr[d] = '0; mWd[d] = '0;   mDone[d] = 1'b0;
  endtask

  // Advance the model by one clock using the inputs that the next edge will sample
  task automatic modelStep(input int d);
    mWe[d] = 1'b0;
    case (mPh[d])
      P_IDLE, P_DONE, P_ERROR: begin
        if (tStart[d]) begin
          mPh[d] = P_PAYLOAD; mCnt[d] = 0; mIdle[d] = 0; mCrc[d] = 16'hFFFF; mDone[d] = 1'b0;
        end else if (mPh[d] == P_DONE) begin
          mDone[d] = 1'b1;
        end
      end
      P_PAYLOAD: begin
        if (tValid[d]) begin
          mWe[d] = 1'b1; mAddr[d] = 10'(mCnt[d]); mWd[d] = tData[d];
          mCrc[d] = crcByte(mCrc[d], tData[d]);
          mCnt[d] = mCnt[d] + 1; mIdle[d] = 0;
          if (mCnt[d] == mLen[d]) mPh[d] = P_CRC_HI;
        end else begin
          mIdle[d] = mIdle[d] + 1;
`ifdef CRC_LOADER_TIMEOUT_EN
          if (mIdle[d] == mTo[d]) mPh[d] = P_ERROR;
`endif
        end
      end
      P_CRC_HI: begin
        mWe[d] = 1'b1; mAddr[d] = 10'(mLen[d]); mWd[d] = mCrc[d][15:8]; mPh[d] = P_CRC_LO;
      end
      default: begin
        mWe[d] = 1'b1; mAddr[d] = 10'(mLen[d] + 1); mWd[d] = mCrc[d][7:0]; mPh[d] = P_DONE;
      end
    endcase
  endtask

  task automatic checkOutput(input int d);
    string s;
    s = (d == 0) ? "s" : "b";
    cmp({s, ".in_ready"},  oReady[d], mPh[d] == P_PAYLOAD);
    cmp({s, ".mem_we"},    oWe[d],    mWe[d]);
    cmp({s, ".mem_addr"},  oAddr[d],  mAddr[d]);
    cmp({s, ".mem_wdata"}, oWd[d],    mWd[d]);
    cmp({s, ".crc_out"},   oCrc[d],   mCrc[d]);
    cmp({s, ".load_busy"}, oBusy[d],  (mPh[d] >= P_PAYLOAD) && (mPh[d] <= P_CRC_LO));
    cmp({s, ".load_done"}, oDone[d],  mDone[d]);
    cmp({s, ".load_err"},  oErr[d],   mPh[d] == P_ERROR);
  endtask

  // Compare process: check every output on the falling edge, record writes, then step the model
  always @(negedge clk50m) begin
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) modelReset(d);
      checkOutput(d);
      if (oWe[d]) begin
        cmp((d == 0) ? "s.wr_seq" : "b.wr_seq", oAddr[d], wrCount[d]);
        memImg[d][oAddr[d]] = oWd[d];
        wrCount[d]++;
      end
      if (rst_n) modelStep(d);
    end
  end

  task automatic tick();
    @(posedge clk50m);
    #1;
  endtask

  task automatic pulseStart(input int d);
    tStart[d] = 1'b1;
    wrCount[d] = 0;
    tick();
    tStart[d] = 1'b0;
  endtask

  // Send n bytes with random idle gaps; mode 0: "123...", 1: i mod 256, 2: random
  task automatic applyStimulus(input int d, input int n, input int mode, input int gapMax,
                               input int startAt);
    int guard;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, gapMax)) begin
        tValid[d] = 1'b0;
        tData[d]  = 8'($urandom);
        tick();
      end
      tValid[d] = 1'b1;
      tData[d]  = (mode == 0) ? 8'(8'h31 + i) : (mode == 1) ? 8'(i) : 8'($urandom);
      if (i == startAt) tStart[d] = 1'b1;
      guard = 0;
      while (!oReady[d] && guard < 50) begin
        tick();
        guard++;
      end
      if (guard >= 50) begin
        nCompared++; nMismatched++;
        $display("[TB] FAIL accept_wait: in_ready stayed 0, got 0 expected 1 (dut %0d)", d);
      end
      tick();
      tStart[d] = 1'b0;
    end
  endtask

  task automatic holdValid(input int d, input int n);
    tValid[d] = 1'b1;
    repeat (n) begin
      tData[d] = 8'($urandom);
      tick();
    end
  endtask

  task automatic waitDone(input int d);
    int guard;
    guard = 0;
    while (!oDone[d] && guard < 20) begin
      tick();
      guard++;
    end
    nCompared++;
    if (!oDone[d]) begin
      nMismatched++;
      $display("[TB] FAIL done_wait: load_done got 0 expected 1 (dut %0d)", d);
    end
  endtask

  initial begin
    $display("[TB] watchdog armed");
    #3ms;
    $display("[TB] FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    mLen[0] = LEN_S; mLen[1] = LEN_B;
    mTo[0]  = TO_S;  mTo[1]  = TO_B;
    for (int d = 0; d < 2; d++) begin
      tStart[d] = 1'b0; tValid[d] = 1'b0; tData[d] = 8'h00; wrCount[d] = 0;
    end
    repeat (3) tick();
    rst_n = 1'b1;

    // Frame 1 (short): "123456789" back-to-back, in_valid held in IDLE and after the payload
    $display("[TB] short frame 123456789");
    holdValid(0, 3);
    pulseStart(0);
    applyStimulus(0, 9, 0, 0, -1);
    holdValid(0, 4);
    waitDone(0);
    cmp("s.mem9", memImg[0][9], 8'h29);
    cmp("s.mem10", memImg[0][10], 8'hB1);
    cmp("s.crc_final", oCrc[0], 16'h29B1);
    cmp("s.model_crc", mCrc[0], 16'h29B1);
    cmp("s.writes", wrCount[0], 11);
    for (int i = 0; i < 9; i++) cmp("s.payload", memImg[0][i], 8'h31 + i);

    // Frame 2 (short): random bytes and gaps, ignored load_start mid-payload
    $display("[TB] short frame random with ignored start");
    pulseStart(0);
    applyStimulus(0, 9, 2, 3, 4);
    holdValid(0, 4);
    waitDone(0);
    cmp("s.residue2", crcOver(0, 11), 16'h0000);
    cmp("s.writes2", wrCount[0], 11);

    // Full-size frame: 1022 bytes i mod 256 with random gaps
    $display("[TB] full-size frame");
    tValid[0] = 1'b0;
    pulseStart(1);
    applyStimulus(1, LEN_B, 1, 3, -1);
    holdValid(1, 4);
    waitDone(1);
    cmp("b.residue", crcOver(1, 1024), 16'h0000);
    cmp("b.writes", wrCount[1], 1024);
    cmp("b.mem1021", memImg[1][1021], 8'hFD);

    // Reset in the middle of a full-size frame, then a fresh short frame
    $display("[TB] reset mid-frame");
    pulseStart(1);
    applyStimulus(1, 100, 2, 2, -1);
    rst_n = 1'b0;
    #1;
    cmp("rst.in_ready", oReady[1], 1'b0);
    cmp("rst.mem_we", oWe[1], 1'b0);
    cmp("rst.mem_addr", oAddr[1], 10'd0);
    cmp("rst.mem_wdata", oWd[1], 8'd0);
    cmp("rst.crc_out", oCrc[1], 16'hFFFF);
    cmp("rst.load_busy", oBusy[1], 1'b0);
    cmp("rst.load_done_s", oDone[0], 1'b0);
    cmp("rst.load_err", oErr[1], 1'b0);
    tValid[1] = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    pulseStart(0);
    applyStimulus(0, 9, 2, 1, -1);
    holdValid(0, 4);
    waitDone(0);
    cmp("s.residue3", crcOver(0, 11), 16'h0000);
    cmp("s.writes3", wrCount[0], 11);

    // Stalled frame: 5 bytes then in_valid low
    $display("[TB] stalled frame");
    pulseStart(0);
    applyStimulus(0, 5, 2, 0, -1);
    tValid[0] = 1'b0;
`ifdef CRC_LOADER_TIMEOUT_EN
    repeat (20) tick();
    cmp("to.load_err", oErr[0], 1'b1);
    cmp("to.load_busy", oBusy[0], 1'b0);
    cmp("to.in_ready", oReady[0], 1'b0);
    cmp("to.writes", wrCount[0], 5);
    pulseStart(0);
    applyStimulus(0, 9, 2, 2, -1);
`else
    repeat (1000) tick();
    cmp("stall.load_err", oErr[0], 1'b0);
    cmp("stall.load_busy", oBusy[0], 1'b1);
    cmp("stall.in_ready", oReady[0], 1'b1);
    cmp("stall.writes", wrCount[0], 5);
    applyStimulus(0, 4, 2, 2, -1);
`endif
    holdValid(0, 4);
    waitDone(0);
    cmp("s.residue4", crcOver(0, 11), 16'h0000);
    tValid[0] = 1'b0;
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
